quant_hist_bank: RTL and testbench

- Parametrised multi-lane front end for ADC sample streams:
  - optional bit-order reversal and Gray-to-binary decode;
  - offset-binary to two's-complement conversion;
  - 2-bit sign/magnitude quantization against a runtime threshold;
  - per-lane 4-bin histograms accumulated over fixed windows of 2^WIN_LOG2 samples.
- Sits between the ADC capture pins and the packet streamer / housekeeping CPU.
- Quantized bits feed the streamer; windowed histogram snapshots are read by the CPU through an indexed port.

---
 rtl/quant_hist_bank_pkg.sv | 24 ++
 rtl/quant_lane.sv | 85 ++++++++
 rtl/quant_hist_bank.sv | 169 ++++++++++++++++
 tb/tb_quant_hist_bank.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/quant_hist_bank_pkg.sv
`timescale 1ns/1ps
// quant_hist_bank_pkg
//   Shared definitions for the quantizer / histogram bank:
//   - histogram bin encoding ({sign, mag} read as a 2-bit index)
//   - layout of one lane's field in q_out
//   - width of the snapshot sequence number
package quant_hist_bank_pkg;

  localparam logic [1:0] BIN_POS_SMALL = 2'd0;
  localparam logic [1:0] BIN_POS_BIG   = 2'd1;
  localparam logic [1:0] BIN_NEG_SMALL = 2'd2;
  localparam logic [1:0] BIN_NEG_BIG   = 2'd3;

  localparam int NBINS = 4;
  localparam int QW    = 2;  // bits per lane in q_out
  localparam int SEQ_W = 8;  // snap_seq width

  // One lane of q_out. As a 2-bit value this is directly the bin index.
  typedef struct packed {
    logic sign;
    logic mag;
  } q_field_t;

endpackage

// File: rtl/quant_lane.sv
`timescale 1ns/1ps
// quant_lane
//   One ADC lane: pin-order reversal, Gray decode and offset-binary to
//   two's-complement conversion (stage 1), then sign/magnitude quantization
//   against thresh (stage 2).
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   load1         capture a new converted sample into stage 1
//   load2         capture a new quantized result into stage 2
//   pin           raw W-bit pin word
//   thresh        magnitude threshold (W-1 bits)
//   q             registered {sign, mag}; holds when load2 is low
module quant_lane
  import quant_hist_bank_pkg::*;
#(
  parameter int W      = 8,
  parameter int GRAY   = 1,
  parameter int BITREV = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load1,
  input  logic         load2,
  input  logic [W-1:0] pin,
  input  logic [W-2:0] thresh,
  output q_field_t     q
);

  function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0] rev_s;
  logic [W-1:0] ord_s;
  logic [W-1:0] bin_s;
  logic [W-1:0] s_c;
  logic [W-1:0] s_r;
  logic [W-2:0] m_s;
  q_field_t     q_c;

  // Undo pin reversal and Gray coding, then flip the MSB (offset -> 2's comp).
  always_comb begin
    for (int i = 0; i < W; i++) begin
      rev_s[i] = pin[W-1-i];
    end
    ord_s = (BITREV != 0) ? rev_s : pin;
    bin_s = (GRAY != 0) ? gray_to_bin(ord_s) : ord_s;
    s_c   = {~bin_s[W-1], bin_s[W-2:0]};
  end

  // Stage 1 register: converted sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_r <= '0;
    end else if (load1) begin
      s_r <= s_c;
    end
  end

  // One's-complement magnitude keeps the most negative code in range.
  always_comb begin
    q_c.sign = s_r[W-1];
    if (s_r[W-1]) begin
      m_s = ~s_r[W-2:0];
    end else begin
      m_s = s_r[W-2:0];
    end
    q_c.mag = (m_s >= thresh);
  end

  // Stage 2 register: quantized output, held between valid samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (load2) begin
      q <= q_c;
    end
  end

endmodule

// File: rtl/quant_hist_bank.sv
`timescale 1ns/1ps
// quant_hist_bank
//   NCH-lane ADC front end: per-lane quantizer (quant_lane) feeding per-lane
//   4-bin saturating histograms accumulated over windows of 2^WIN_LOG2
//   counted samples, with snapshot registers read through an indexed port.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in_valid, in_data   input samples, lane k at [k*W +: W]
//   thresh              magnitude threshold
//   enable              histogram counting enable
//   clear               zero live counters and window counter
//   q_valid, q_out      quantized stream, lane k at [2k +: 2] = {sign, mag}
//   snap_pulse          one-cycle strobe when a new snapshot is readable
//   snap_seq            snapshot sequence number (wraps)
//   rd_ch, rd_bin       snapshot select
//   rd_data             selected snapshot count, one cycle after select
module quant_hist_bank
  import quant_hist_bank_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 8,
  parameter int GRAY     = 1,
  parameter int BITREV   = 1,
  parameter int WIN_LOG2 = 16,
  parameter int CW       = 17,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [NCH*W-1:0]   in_data,
  input  logic [W-2:0]       thresh,
  input  logic               enable,
  input  logic               clear,
  output logic               q_valid,
  output logic [NCH*QW-1:0]  q_out,
  output logic               snap_pulse,
  output logic [SEQ_W-1:0]   snap_seq,
  input  logic [CHW-1:0]     rd_ch,
  input  logic [1:0]         rd_bin,
  output logic [CW-1:0]      rd_data
);

  q_field_t            lane_q     [NCH];
  logic                v1_r;
  logic [CW-1:0]       live_r     [NCH][NBINS];
  logic [CW-1:0]       live_nxt_s [NCH][NBINS];
  logic [CW-1:0]       snap_r     [NCH][NBINS];
  logic [WIN_LOG2-1:0] win_r;
  logic                count_s;
  logic                win_end_s;
  logic [CW-1:0]       rd_sel_s;

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_lane
      quant_lane #(
        .W      (W),
        .GRAY   (GRAY),
        .BITREV (BITREV)
      ) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .load1   (in_valid),
        .load2   (v1_r),
        .pin     (in_data[k*W +: W]),
        .thresh  (thresh),
        .q       (lane_q[k])
      );
      assign q_out[k*QW +: QW] = lane_q[k];
    end
  endgenerate

  // Valid pipeline alongside the two lane stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_r    <= 1'b0;
      q_valid <= 1'b0;
    end else begin
      v1_r    <= in_valid;
      q_valid <= v1_r;
    end
  end

  // Counting qualifier and window-end detect.
  always_comb begin
    count_s   = q_valid & enable;
    win_end_s = count_s & (&win_r);
  end

  // Saturating increment of the bin selected by each lane's {sign, mag}.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int b = 0; b < NBINS; b++) begin
        if ((lane_q[c] == QW'(b)) && (live_r[c][b] != {CW{1'b1}})) begin
          live_nxt_s[c][b] = live_r[c][b] + CW'(1'b1);
        end else begin
          live_nxt_s[c][b] = live_r[c][b];
        end
      end
    end
  end

  // Live counters, window counter, snapshots and sequence number.
  // clear has priority, so a coinciding window end is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          live_r[c][b] <= '0;
          snap_r[c][b] <= '0;
        end
      end
      win_r    <= '0;
      snap_seq <= '0;
    end else if (clear) begin
      for (int c = 0; c < NCH; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          live_r[c][b] <= '0;
        end
      end
      win_r <= '0;
    end else if (win_end_s) begin
      // Snapshot includes the sample that closes the window.
      for (int c = 0; c < NCH; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          snap_r[c][b] <= live_nxt_s[c][b];
          live_r[c][b] <= '0;
        end
      end
      win_r    <= '0;
      snap_seq <= snap_seq + SEQ_W'(1'b1);
    end else if (count_s) begin
      for (int c = 0; c < NCH; c++) begin
        for (int b = 0; b < NBINS; b++) begin
          live_r[c][b] <= live_nxt_s[c][b];
        end
      end
      win_r <= win_r + WIN_LOG2'(1'b1);
    end
  end

  // Snapshot-ready strobe, aligned with the snapshot register update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_pulse <= 1'b0;
    end else begin
      snap_pulse <= win_end_s & ~clear;
    end
  end

  // Readout mux; an rd_ch beyond the last lane matches nothing and reads 0.
  always_comb begin
    rd_sel_s = '0;
    for (int c = 0; c < NCH; c++) begin
      rd_sel_s = rd_sel_s | ({CW{rd_ch == CHW'(c)}} & snap_r[c][rd_bin]);
    end
  end

  // Registered readout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_sel_s;
    end
  end

endmodule

// File: tb/tb_quant_hist_bank.sv
`timescale 1ns/1ps
// Bench: two instances share control and sample values. dut_p sees plain
// offset-binary pins (GRAY=0, BITREV=0, CW=8); dut_g sees the bit-reversed
// Gray encoding of the same values (GRAY=1, BITREV=1, CW=3 to saturate).
// Both use 16-sample windows and 3 lanes, so rd_ch=3 is out of range.
module tb_quant_hist_bank;
  import quant_hist_bank_pkg::*;

  localparam int NCH  = 3;
  localparam int W    = 8;
  localparam int WL   = 4;
  localparam int WIN  = 16;
  localparam int CWP  = 8;
  localparam int CWG  = 3;
  localparam int MAXP = (1 << CWP) - 1;
  localparam int MAXG = (1 << CWG) - 1;

  logic             clk = 1'b0;
  logic             reset_n, in_valid, enable, clear;
  logic [NCH*W-1:0] data_p, data_g;
  logic [W-2:0]     thresh;
  logic [1:0]       rd_ch, rd_bin;
  logic             qv_p, qv_g, sp_p, sp_g;
  logic [NCH*2-1:0] q_p, q_g;
  logic [7:0]       seq_p, seq_g;
  logic [CWP-1:0]   rd_p;
  logic [CWG-1:0]   rd_g;
  logic [7:0]       smp [NCH];

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] codes [4] = '{8'hA0, 8'h80, 8'h5F, 8'h7F};
  logic [1:0] qexp  [4] = '{2'b01, 2'b00, 2'b11, 2'b10};

  // Behavioural model state
  logic       m_v1, m_qv, m_pulse;
  logic [7:0] m_s1 [NCH];
  logic [1:0] m_q  [NCH];
  int m_live_p [NCH][4];
  int m_live_g [NCH][4];
  int m_snap_p [NCH][4];
  int m_snap_g [NCH][4];
  int m_win, m_seq, m_rd_p, m_rd_g;

  always #5 clk = ~clk;

  quant_hist_bank #(.NCH(NCH), .W(W), .GRAY(0), .BITREV(0), .WIN_LOG2(WL), .CW(CWP)) dut_p (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(data_p), .thresh(thresh),
    .enable(enable), .clear(clear), .q_valid(qv_p), .q_out(q_p), .snap_pulse(sp_p),
    .snap_seq(seq_p), .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_data(rd_p)
  );

  quant_hist_bank #(.NCH(NCH), .W(W), .GRAY(1), .BITREV(1), .WIN_LOG2(WL), .CW(CWG)) dut_g (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(data_g), .thresh(thresh),
    .enable(enable), .clear(clear), .q_valid(qv_g), .q_out(q_g), .snap_pulse(sp_g),
    .snap_seq(seq_g), .rd_ch(rd_ch), .rd_bin(rd_bin), .rd_data(rd_g)
  );

  // Gray-encode, then reverse pin order (pin bit 0 carries the MSB).
  function automatic logic [7:0] enc(input logic [7:0] v);
    logic [7:0] g, r;
    g = v ^ (v >> 1);
    for (int i = 0; i < 8; i++) r[i] = g[7-i];
    return r;
  endfunction

  // Quantizer from the arithmetic definition: signed value = code - 128.
  function automatic logic [1:0] quant(input logic [7:0] v, input logic [6:0] th);
    int s, m;
    logic sg, mg;
    s  = int'(v) - 128;
    sg = (s < 0);
    m  = sg ? (-s - 1) : s;
    mg = (m >= int'(th));
    return {sg, mg};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic put(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    smp[0] = a; smp[1] = b; smp[2] = c;
    in_valid = v;
    data_p = {c, b, a};
    data_g = {enc(c), enc(b), enc(a)};
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_step();
    int bn;
    if (!reset_n) begin
      m_v1 = 1'b0; m_qv = 1'b0; m_pulse = 1'b0;
      m_win = 0; m_seq = 0; m_rd_p = 0; m_rd_g = 0;
      for (int k = 0; k < NCH; k++) begin
        m_s1[k] = 8'd0; m_q[k] = 2'd0;
        for (int b = 0; b < 4; b++) begin
          m_live_p[k][b] = 0; m_live_g[k][b] = 0; m_snap_p[k][b] = 0; m_snap_g[k][b] = 0;
        end
      end
    end else begin
      if (int'(rd_ch) < NCH) begin
        m_rd_p = m_snap_p[rd_ch][rd_bin];
        m_rd_g = m_snap_g[rd_ch][rd_bin];
      end else begin
        m_rd_p = 0; m_rd_g = 0;
      end
      m_pulse = 1'b0;
      if (clear) begin
        m_win = 0;
        for (int k = 0; k < NCH; k++)
          for (int b = 0; b < 4; b++) begin m_live_p[k][b] = 0; m_live_g[k][b] = 0; end
      end else if (m_qv && enable) begin
        for (int k = 0; k < NCH; k++) begin
          bn = int'(m_q[k]);
          if (m_live_p[k][bn] < MAXP) m_live_p[k][bn]++;
          if (m_live_g[k][bn] < MAXG) m_live_g[k][bn]++;
        end
        m_win++;
        if (m_win == WIN) begin
          m_win = 0; m_pulse = 1'b1; m_seq = (m_seq + 1) % 256;
          for (int k = 0; k < NCH; k++)
            for (int b = 0; b < 4; b++) begin
              m_snap_p[k][b] = m_live_p[k][b]; m_snap_g[k][b] = m_live_g[k][b];
              m_live_p[k][b] = 0; m_live_g[k][b] = 0;
            end
        end
      end
      if (m_v1) for (int k = 0; k < NCH; k++) m_q[k] = quant(m_s1[k], thresh);
      m_qv = m_v1;
      m_v1 = in_valid;
      if (in_valid) for (int k = 0; k < NCH; k++) m_s1[k] = smp[k];
    end
  endtask

  task automatic compare();
    logic [5:0] qe;
    qe = {m_q[2], m_q[1], m_q[0]};
    chk("q_valid_p", qv_p, m_qv);
    chk("q_valid_g", qv_g, m_qv);
    chk("q_out_p", q_p, qe);
    chk("q_out_g", q_g, qe);
    chk("snap_pulse_p", sp_p, m_pulse);
    chk("snap_pulse_g", sp_g, m_pulse);
    chk("snap_seq_p", seq_p, m_seq);
    chk("snap_seq_g", seq_g, m_seq);
    chk("rd_data_p", rd_p, m_rd_p);
    chk("rd_data_g", rd_g, m_rd_g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_step();
    compare();
  endtask

  task automatic feed(input int n, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    repeat (n) begin
      put(1'b1, a, b, c);
      step();
    end
  endtask

  // Called right after the edge that captured the last sample of a window.
  task automatic drain(input string nm, input logic pulse_exp, input int seq_exp, input logic clr);
    in_valid = 1'b0;
    step();
    chk({nm, "_pulse_early"}, sp_p, 1'b0);
    clear = clr;
    step();
    chk({nm, "_pulse_p"}, sp_p, pulse_exp);
    chk({nm, "_pulse_g"}, sp_g, pulse_exp);
    chk({nm, "_seq"}, seq_p, seq_exp);
    clear = 1'b0;
    step();
    chk({nm, "_pulse_once"}, sp_p, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [1:0] ch, input logic [1:0] bn, input int ep, input int eg);
    rd_ch = ch; rd_bin = bn;
    step();
    chk({nm, "_p"}, rd_p, ep);
    chk({nm, "_g"}, rd_g, eg);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; clear = 1'b0; thresh = 7'd32;
    rd_ch = 2'd0; rd_bin = 2'd0;
    put(1'b0, 8'h80, 8'h80, 8'h80);
    repeat (3) step();
    chk("reset_q_valid", qv_p, 1'b0);
    chk("reset_seq", seq_g, 8'd0);
    reset_n = 1'b1;

    // Quantizer codes and 2-cycle latency on both encodings
    for (int i = 0; i < 4; i++) begin
      put(1'b1, codes[i], codes[i], codes[i]);
      step();
      chk("lat1_valid", qv_p, 1'b0);
      put(1'b0, codes[i], codes[i], codes[i]);
      step();
      chk("lat2_valid", qv_g, 1'b1);
      chk("code_plain", q_p[1:0], qexp[i]);
      chk("code_graybitrev", q_g[1:0], qexp[i]);
      step();
      chk("code_hold", q_p[1:0], qexp[i]);
    end

    // Sweep all codes with a threshold changing every cycle
    for (int v = 0; v < 256; v++) begin
      thresh = 7'(v);
      put(1'b1, 8'(v), 8'(255 - v), 8'(v) ^ 8'h5A);
      step();
    end
    put(1'b0, 8'h80, 8'h80, 8'h80);
    step(); step();
    thresh = 7'd32;

    // First window: 10 x +big, 6 x +small on lane 0
    enable = 1'b1; clear = 1'b1; step(); clear = 1'b0;
    rd_ch = 2'd0; rd_bin = BIN_POS_BIG;
    feed(10, 8'hA0, 8'h5F, 8'h7F);
    feed(6, 8'h80, 8'h5F, 8'h7F);
    drain("win1", 1'b1, 1, 1'b0);
    rd("w1_l0_posbig", 2'd0, BIN_POS_BIG, 10, 7);
    rd("w1_l0_possmall", 2'd0, BIN_POS_SMALL, 6, 6);
    rd("w1_l0_negsmall", 2'd0, BIN_NEG_SMALL, 0, 0);
    rd("w1_l0_negbig", 2'd0, BIN_NEG_BIG, 0, 0);
    rd("w1_l1_negbig", 2'd1, BIN_NEG_BIG, 16, 7);
    rd("w1_l2_negsmall", 2'd2, BIN_NEG_SMALL, 16, 7);
    rd("w1_ch_oob", 2'd3, BIN_POS_BIG, 0, 0);

    // Saturation: 16 identical samples
    feed(16, 8'hA0, 8'hA0, 8'hA0);
    drain("sat", 1'b1, 2, 1'b0);
    rd("sat_posbig", 2'd0, BIN_POS_BIG, 16, 7);
    rd("sat_possmall", 2'd0, BIN_POS_SMALL, 0, 0);

    // Reset mid-stream
    feed(5, 8'hA0, 8'hA0, 8'hA0);
    reset_n = 1'b0;
    #1;
    chk("rst_q_valid", qv_p, 1'b0);
    chk("rst_q_out", q_p, 6'd0);
    chk("rst_seq", seq_p, 8'd0);
    chk("rst_rd_data", rd_p, 8'd0);
    chk("rst_pulse", sp_g, 1'b0);
    put(1'b0, 8'h80, 8'h80, 8'h80);
    step();
    reset_n = 1'b1;
    rd("rst_snap", 2'd0, BIN_POS_BIG, 0, 0);

    // Enable gap: uncounted samples in the middle of a window
    rd_bin = BIN_POS_BIG;
    feed(8, 8'hA0, 8'hA0, 8'hA0);
    in_valid = 1'b0; step(); step();
    enable = 1'b0;
    feed(5, 8'h80, 8'h80, 8'h80);
    in_valid = 1'b0; step(); step();
    enable = 1'b1;
    feed(8, 8'hA0, 8'hA0, 8'hA0);
    drain("en_gap", 1'b1, 1, 1'b0);
    rd("gap_posbig", 2'd0, BIN_POS_BIG, 16, 7);
    rd("gap_possmall", 2'd0, BIN_POS_SMALL, 0, 0);

    // Clear after 8 samples
    feed(8, 8'hA0, 8'hA0, 8'hA0);
    in_valid = 1'b0; step(); step();
    clear = 1'b1; step(); clear = 1'b0;
    rd("clr_old_snap", 2'd0, BIN_POS_BIG, 16, 7);
    feed(16, 8'h80, 8'h80, 8'h80);
    drain("after_clr", 1'b1, 2, 1'b0);
    rd("clr_possmall", 2'd0, BIN_POS_SMALL, 16, 7);
    rd("clr_posbig", 2'd0, BIN_POS_BIG, 0, 0);

    // Clear coinciding with the window-closing sample
    feed(16, 8'h5F, 8'h5F, 8'h5F);
    drain("clr_coinc", 1'b0, 2, 1'b1);
    rd("coinc_negbig", 2'd0, BIN_NEG_BIG, 0, 0);
    rd("coinc_possmall", 2'd0, BIN_POS_SMALL, 16, 7);

    // Sequence wrap
    for (int w = 0; w < 253; w++) begin
      thresh = 7'($urandom);
      for (int s = 0; s < WIN; s++) begin
        put(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
        step();
      end
    end
    in_valid = 1'b0; step(); step(); step();
    chk("seq_255", seq_p, 8'd255);
    feed(16, 8'h7F, 8'h00, 8'hFF);
    drain("wrap", 1'b1, 0, 1'b0);
    rd("wrap_l0", 2'd0, BIN_NEG_SMALL, 16, 7);
    rd("wrap_l1", 2'd1, BIN_NEG_BIG, 16, 7);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
